// File: rtl/dmem_dumper_if.sv
// Bus bundle for dmem_dumper: the CPU MEM-stage port, the data-memory port and the dump stream.
// The master modport is the dumper's view; the slave modport is the surrounding system's view.
interface dmem_dumper_if;
    logic        start;
    logic [31:0] cpu_address;
    logic [31:0] cpu_writeData;
    logic        cpu_memRead;
    logic        cpu_memWrite;
    logic [31:0] cpu_readData;
    logic [31:0] mem_address;
    logic [31:0] mem_writeData;
    logic        mem_memRead;
    logic        mem_memWrite;
    logic [31:0] mem_readData;
    logic        busy;
    logic        dump_valid;
    logic        dump_ready;
    logic [31:0] dump_addr;
    logic [31:0] dump_data;
    logic        dump_last;
    logic        done;

    modport master (
        input  start, cpu_address, cpu_writeData, cpu_memRead, cpu_memWrite, mem_readData,
               dump_ready,
        output cpu_readData, mem_address, mem_writeData, mem_memRead, mem_memWrite, busy,
               dump_valid, dump_addr, dump_data, dump_last, done
    );

    modport slave (
        output start, cpu_address, cpu_writeData, cpu_memRead, cpu_memWrite, mem_readData,
               dump_ready,
        input  cpu_readData, mem_address, mem_writeData, mem_memRead, mem_memWrite, busy,
               dump_valid, dump_addr, dump_data, dump_last, done
    );
endinterface

// File: rtl/dmem_dumper.sv
// Data-memory dump controller: passes CPU accesses through in IDLE, otherwise streams every word.
// Optional DMEM_DUMP_SKIP_ZERO_EN suppresses beats for words that read as zero.
module dmem_dumper #(
    parameter int unsigned NUMS = 32
) (
    input  logic          clk,
    input  logic          reset,
    dmem_dumper_if.master bus_io
);
    localparam int unsigned IdxW = (NUMS > 1) ? $clog2(NUMS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUMS - 1);

    typedef enum logic [1:0] {StIdle, StRead, StSend, StDone} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [31:0]     buf_q, buf_d;
    logic [31:0]     idx_addr;
    logic            idx_last;

    assign idx_addr = {{(30 - IdxW){1'b0}}, idx_q, 2'b00};
    assign idx_last = (idx_q == LastIdx);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d               = state_q;
        idx_d                 = idx_q;
        buf_d                 = buf_q;
        bus_io.cpu_readData   = '0;
        bus_io.mem_address    = '0;
        bus_io.mem_writeData  = '0;
        bus_io.mem_memRead    = 1'b0;
        bus_io.mem_memWrite   = 1'b0;
        bus_io.busy           = (state_q != StIdle);
        bus_io.dump_valid     = 1'b0;
        bus_io.dump_addr      = '0;
        bus_io.dump_data      = '0;
        bus_io.dump_last      = 1'b0;
        bus_io.done           = 1'b0;

        unique case (state_q)
            StIdle: begin
                bus_io.mem_address   = bus_io.cpu_address;
                bus_io.mem_writeData = bus_io.cpu_writeData;
                bus_io.mem_memRead   = bus_io.cpu_memRead;
                bus_io.mem_memWrite  = bus_io.cpu_memWrite;
                bus_io.cpu_readData  = bus_io.mem_readData;
                if (bus_io.start) begin
                    idx_d   = '0;
                    state_d = StRead;
                end
            end
            StRead: begin
                bus_io.mem_address = idx_addr;
                bus_io.mem_memRead = 1'b1;
`ifdef DMEM_DUMP_SKIP_ZERO_EN
                // Zero words are skipped without a beat; completion is signalled only by done.
                if (bus_io.mem_readData == '0) begin
                    if (idx_last) begin
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    buf_d   = bus_io.mem_readData;
                    state_d = StSend;
                end
`else
                buf_d   = bus_io.mem_readData;
                state_d = StSend;
`endif
            end
            StSend: begin
                bus_io.dump_valid = 1'b1;
                bus_io.dump_addr  = idx_addr;
                bus_io.dump_data  = buf_q;
                bus_io.dump_last  = idx_last;
                if (bus_io.dump_ready) begin
                    if (idx_last) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StRead;
                    end
                end
            end
            StDone: begin
                bus_io.done = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end
endmodule

// File: tb/tb_dmem_dumper.sv
// Directed bench for dmem_dumper: passthrough, full dump timing, backpressure, busy lockout,
// mid-dump reset and (with DMEM_DUMP_SKIP_ZERO_EN) zero-word skipping.
module tb_dmem_dumper;
    localparam int unsigned Nums = 32;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    dmem_dumper_if bus ();

    dmem_dumper #(.NUMS(Nums)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus)
    );

    // Data memory: combinational read, write on falling edge.
    logic [31:0] mem [Nums];
    assign bus.mem_readData = mem[bus.mem_address[6:2]];
    always @(negedge clk) begin
        if (bus.mem_memWrite) mem[bus.mem_address[6:2]] = bus.mem_writeData;
    end

    task automatic idle_inputs();
        bus.start         = 1'b0;
        bus.cpu_address   = '0;
        bus.cpu_writeData = '0;
        bus.cpu_memRead   = 1'b0;
        bus.cpu_memWrite  = 1'b0;
        bus.dump_ready    = 1'b1;
    endtask

    task automatic preload_inc();
        for (int i = 0; i < Nums; i++) mem[i] = 32'(i + 1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        #12;
        n_vec++; if (bus.busy !== 1'b0) begin n_err++;
            $display("FAIL reset_busy got %0b want 0", bus.busy); end
        n_vec++; if (bus.dump_valid !== 1'b0) begin n_err++;
            $display("FAIL reset_valid got %0b want 0", bus.dump_valid); end
        n_vec++; if (bus.dump_addr !== 32'h0 || bus.dump_data !== 32'h0) begin n_err++;
            $display("FAIL reset_dump got %h/%h want 0/0", bus.dump_addr, bus.dump_data); end
        n_vec++; if (bus.dump_last !== 1'b0 || bus.done !== 1'b0) begin n_err++;
            $display("FAIL reset_last_done got %0b/%0b want 0/0", bus.dump_last, bus.done); end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_passthrough();
        @(posedge clk); #1;
        bus.cpu_address   = 32'd8;
        bus.cpu_writeData = 32'hDEADBEEF;
        bus.cpu_memWrite  = 1'b1;
        #1;
        n_vec++; if (bus.mem_memWrite !== 1'b1 || bus.mem_address !== 32'd8) begin n_err++;
            $display("FAIL pass_store got we=%0b addr=%h want 1/8",
                     bus.mem_memWrite, bus.mem_address); end
        @(posedge clk); #1;
        bus.cpu_memWrite = 1'b0;
        bus.cpu_memRead  = 1'b1;
        #1;
        n_vec++; if (bus.cpu_readData !== 32'hDEADBEEF) begin n_err++;
            $display("FAIL pass_load got %h want deadbeef", bus.cpu_readData); end
        n_vec++; if (bus.busy !== 1'b0 || bus.dump_valid !== 1'b0) begin n_err++;
            $display("FAIL pass_idle got busy=%0b valid=%0b want 0/0", bus.busy,
                     bus.dump_valid); end
        idle_inputs();
    endtask

    // Dump with dump_ready low for `stall` cycles starting at beat 5 (cycle 12).
    // With `inject`, a start pulse and a store to address 0 are issued in cycle 5.
    task automatic run_dump(input int stall, input bit inject, input string tag);
        int exp_k;
        int c2;
        @(posedge clk); #1;
        bus.start = 1'b1;
        for (int c = 1; c <= 70 + stall; c++) begin
            @(posedge clk); #1;
            idle_inputs();
            bus.dump_ready = !(stall > 0 && c >= 12 && c < 12 + stall);
            if (inject && c == 5) begin
                bus.start         = 1'b1;
                bus.cpu_address   = 32'd0;
                bus.cpu_writeData = 32'd5;
                bus.cpu_memWrite  = 1'b1;
                bus.cpu_memRead   = 1'b1;
            end
            #1;
            exp_k = -1;
            if (c < 12) begin
                if (c >= 2 && c % 2 == 0) exp_k = (c - 2) / 2;
            end else if (c <= 12 + stall) begin
                exp_k = 5;
            end else begin
                c2 = c - stall;
                if (c2 % 2 == 0 && c2 <= 64) exp_k = (c2 - 2) / 2;
            end
            n_vec++; if (bus.dump_valid !== (exp_k >= 0)) begin n_err++;
                $display("FAIL %s_valid c=%0d got %0b want %0b", tag, c, bus.dump_valid,
                         exp_k >= 0); end
            if (exp_k >= 0) begin
                n_vec++;
                if (bus.dump_addr !== 32'(exp_k * 4) || bus.dump_data !== 32'(exp_k + 1)
                    || bus.dump_last !== (exp_k == 31)) begin
                    n_err++;
                    $display("FAIL %s_beat c=%0d got %h/%h/%0b want %h/%h/%0b", tag, c,
                             bus.dump_addr, bus.dump_data, bus.dump_last, 32'(exp_k * 4),
                             32'(exp_k + 1), exp_k == 31);
                end
            end
            n_vec++; if (bus.done !== (c == 65 + stall)) begin n_err++;
                $display("FAIL %s_done c=%0d got %0b", tag, c, bus.done); end
            n_vec++; if (bus.busy !== (c <= 65 + stall)) begin n_err++;
                $display("FAIL %s_busy c=%0d got %0b", tag, c, bus.busy); end
            if (inject && c == 5) begin
                n_vec++; if (bus.cpu_readData !== 32'h0 || bus.mem_memWrite !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s_lockout got rd=%h we=%0b want 0/0", tag,
                             bus.cpu_readData, bus.mem_memWrite);
                end
            end
        end
        idle_inputs();
        if (inject) begin
            n_vec++; if (mem[0] !== 32'd1) begin n_err++;
                $display("FAIL %s_word0 got %h want 1", tag, mem[0]); end
        end
    endtask

    task automatic test_full_dump();
        preload_inc();
        run_dump(0, 1'b0, "full");
    endtask

    task automatic test_backpressure();
        preload_inc();
        run_dump(3, 1'b0, "stall");
    endtask

    task automatic test_start_while_busy();
        preload_inc();
        run_dump(0, 1'b1, "busy");
    endtask

    task automatic test_reset_mid_dump();
        preload_inc();
        @(posedge clk); #1;
        bus.start = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        #1;
        n_vec++; if (bus.dump_valid !== 1'b1 || bus.dump_addr !== 32'd40) begin n_err++;
            $display("FAIL rst_beat10 got %0b/%h want 1/28", bus.dump_valid, bus.dump_addr); end
        reset = 1'b1;
        #1;
        n_vec++; if (bus.busy !== 1'b0 || bus.dump_valid !== 1'b0) begin n_err++;
            $display("FAIL rst_drop got busy=%0b valid=%0b want 0/0", bus.busy,
                     bus.dump_valid); end
        @(posedge clk); #1;
        reset = 1'b0;
        run_dump(0, 1'b0, "restart");
    endtask

`ifdef DMEM_DUMP_SKIP_ZERO_EN
    task automatic test_skip_zero();
        for (int i = 0; i < Nums; i++) mem[i] = 32'h0;
        mem[3] = 32'h11;
        mem[7] = 32'h22;
        @(posedge clk); #1;
        bus.start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            #1;
            n_vec++; if (bus.dump_valid !== (c == 5 || c == 10)) begin n_err++;
                $display("FAIL skip_valid c=%0d got %0b", c, bus.dump_valid); end
            if (c == 5) begin
                n_vec++; if (bus.dump_addr !== 32'd12 || bus.dump_data !== 32'h11) begin
                    n_err++;
                    $display("FAIL skip_beat0 got %h/%h want c/11", bus.dump_addr,
                             bus.dump_data);
                end
            end
            if (c == 10) begin
                n_vec++; if (bus.dump_addr !== 32'd28 || bus.dump_data !== 32'h22) begin
                    n_err++;
                    $display("FAIL skip_beat1 got %h/%h want 1c/22", bus.dump_addr,
                             bus.dump_data);
                end
            end
            n_vec++; if (bus.dump_last !== 1'b0) begin n_err++;
                $display("FAIL skip_last c=%0d got %0b want 0", c, bus.dump_last); end
            n_vec++; if (bus.done !== (c == 35)) begin n_err++;
                $display("FAIL skip_done c=%0d got %0b", c, bus.done); end
            n_vec++; if (bus.busy !== (c <= 35)) begin n_err++;
                $display("FAIL skip_busy c=%0d got %0b", c, bus.busy); end
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < Nums; i++) mem[i] = 32'h0;
        test_reset();
        test_passthrough();
        test_full_dump();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid_dump();
`ifdef DMEM_DUMP_SKIP_ZERO_EN
        test_skip_zero();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
